// File: rtl/coin_detector.sv
// Coin-slot front end: synchronizes and debounces the sensor, then emits
// one accept (c) or reject strobe per coin and flags coins that stay too long.
module coin_detector #(
    parameter int DEBOUNCE   = 4,
    parameter int JAM_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_sense,
    input  logic [1:0] coin_type,
    input  logic       en,
    output logic       c,
    output logic [7:0] a,
    output logic       reject,
    output logic       jam
);

    localparam logic [7:0]  DEB_MAX = 8'(DEBOUNCE);
    localparam logic [15:0] JAM_MAX = 16'(JAM_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        DEB_ON,
        HOLD,
        DEB_OFF
    } state_e;

    logic       sense_s1_q, sense_s2_q;
    logic [1:0] type_s1_q, type_s2_q;

    state_e      state_q, state_d;
    logic [7:0]  deb_cnt_q, deb_cnt_d;
    logic [15:0] jam_cnt_q, jam_cnt_d;
    logic        c_q, c_d;
    logic        reject_q, reject_d;
    logic        jam_q, jam_d;
    logic [7:0]  a_q, a_d;

    logic       s;
    logic       coin_ok;
    logic [7:0] coin_val;

    assign s       = sense_s2_q;
    assign coin_ok = en && (type_s2_q != 2'd3);

    always_comb begin
        coin_val = 8'd0;
        unique case (type_s2_q)
            2'd0:    coin_val = 8'd5;
            2'd1:    coin_val = 8'd10;
            2'd2:    coin_val = 8'd25;
            default: coin_val = 8'd0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        jam_cnt_d = jam_cnt_q;
        c_d       = 1'b0;
        reject_d  = 1'b0;
        jam_d     = jam_q;
        a_d       = a_q;
        unique case (state_q)
            IDLE: begin
                if (s) begin
                    deb_cnt_d = 8'd1;
                    state_d   = DEB_ON;
                end
            end
            DEB_ON: begin
                if (!s) begin
                    state_d = IDLE;
                end else if (deb_cnt_q == DEB_MAX) begin
                    // en and the coin type are sampled only on this edge
                    state_d = HOLD;
                    if (coin_ok) begin
                        c_d = 1'b1;
                        a_d = coin_val;
                    end else begin
                        reject_d = 1'b1;
                    end
                end else begin
                    deb_cnt_d = deb_cnt_q + 8'd1;
                end
            end
            HOLD: begin
                if (jam_cnt_q != JAM_MAX) begin
                    jam_cnt_d = jam_cnt_q + 16'd1;
                end
                jam_d = (jam_cnt_d == JAM_MAX);
                if (!s) begin
                    deb_cnt_d = 8'd1;
                    state_d   = DEB_OFF;
                end
            end
            DEB_OFF: begin
                if (s) begin
                    state_d = HOLD;
                end else if (deb_cnt_q == DEB_MAX) begin
                    state_d   = IDLE;
                    jam_cnt_d = 16'd0;
                    jam_d     = 1'b0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sense_s1_q <= 1'b0;
            sense_s2_q <= 1'b0;
            type_s1_q  <= 2'd0;
            type_s2_q  <= 2'd0;
            state_q    <= IDLE;
            deb_cnt_q  <= 8'd0;
            jam_cnt_q  <= 16'd0;
            c_q        <= 1'b0;
            reject_q   <= 1'b0;
            jam_q      <= 1'b0;
            a_q        <= 8'd0;
        end else begin
            sense_s1_q <= coin_sense;
            sense_s2_q <= sense_s1_q;
            type_s1_q  <= coin_type;
            type_s2_q  <= type_s1_q;
            state_q    <= state_d;
            deb_cnt_q  <= deb_cnt_d;
            jam_cnt_q  <= jam_cnt_d;
            c_q        <= c_d;
            reject_q   <= reject_d;
            jam_q      <= jam_d;
            a_q        <= a_d;
        end
    end

    assign c      = c_q;
    assign reject = reject_q;
    assign jam    = jam_q;
    assign a      = a_q;

endmodule

// File: tb/tb_coin_detector.sv
// Scenario bench for coin_detector: directed cases plus randomized coins
// checked against timing rules computed from edge arithmetic.
module tb_coin_detector;

    localparam int D   = 4;
    localparam int JAM = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       coin_sense = 1'b0;
    logic [1:0] coin_type = 2'd0;
    logic       en = 1'b0;
    logic       c, reject, jam;
    logic [7:0] a;

    logic       sense1 = 1'b0;
    logic [1:0] type1 = 2'd1;
    logic       en1 = 1'b1;
    logic       c1, reject1, jam1;
    logic [7:0] a1;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [7:0] exp_a = 8'd0;

    int c_cnt = 0;
    int rej_cnt = 0;
    int strobe_edge = -1;
    int jam_rise = -1;
    int jam_fall = -1;
    int acc = 0;
    logic [7:0] a_at_strobe = 8'd0;
    logic jam_prev = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    coin_detector #(.DEBOUNCE(D), .JAM_CYCLES(JAM)) dut (
        .clk(clk), .rst(rst), .coin_sense(coin_sense),
        .coin_type(coin_type), .en(en), .c(c), .a(a),
        .reject(reject), .jam(jam)
    );

    coin_detector #(.DEBOUNCE(1), .JAM_CYCLES(3)) dut1 (
        .clk(clk), .rst(rst), .coin_sense(sense1),
        .coin_type(type1), .en(en1), .c(c1), .a(a1),
        .reject(reject1), .jam(jam1)
    );

    // strobe / jam observer, sampled mid-cycle
    always @(negedge clk) begin
        if (c === 1'b1) begin
            c_cnt++;
            strobe_edge = cyc;
            a_at_strobe = a;
            acc += int'(a);
        end
        if (reject === 1'b1) begin
            rej_cnt++;
            strobe_edge = cyc;
        end
        if (jam === 1'b1 && jam_prev !== 1'b1) jam_rise = cyc;
        if (jam !== 1'b1 && jam_prev === 1'b1) jam_fall = cyc;
        jam_prev = jam;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input int n);
        for (int i = 0; i < n; i++) begin
            coin_sense = s;
            tick();
        end
    endtask

    function automatic logic [7:0] value_of(input logic [1:0] t);
        if (t == 2'd0) return 8'd5;
        if (t == 2'd1) return 8'd10;
        if (t == 2'd2) return 8'd25;
        return 8'd0;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        tests++;
        if (c !== 1'b0) begin
            fails++;
            $display("FAIL reset_c: got %b want 0", c);
        end
        tests++;
        if (reject !== 1'b0) begin
            fails++;
            $display("FAIL reset_reject: got %b want 0", reject);
        end
        tests++;
        if (jam !== 1'b0) begin
            fails++;
            $display("FAIL reset_jam: got %b want 0", jam);
        end
        tests++;
        if (a !== 8'd0) begin
            fails++;
            $display("FAIL reset_a: got %0d want 0", a);
        end
        rst = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_clean_dime();
        int c0, r0, n;
        c0 = c_cnt;
        r0 = rej_cnt;
        coin_type = 2'd1;
        en = 1'b1;
        drive(1'b0, 2);
        n = cyc + 1;
        drive(1'b1, 20);
        exp_a = 8'd10;
        drive(1'b0, D + 10);
        tests++;
        if (c_cnt - c0 !== 1) begin
            fails++;
            $display("FAIL dime_c_count: got %0d want 1", c_cnt - c0);
        end
        tests++;
        if (strobe_edge !== n + 2 + D) begin
            fails++;
            $display("FAIL dime_edge: got %0d want %0d", strobe_edge, n + 2 + D);
        end
        tests++;
        if (a_at_strobe !== 8'd10) begin
            fails++;
            $display("FAIL dime_a_strobe: got %0d want 10", a_at_strobe);
        end
        tests++;
        if (rej_cnt - r0 !== 0) begin
            fails++;
            $display("FAIL dime_reject: got %0d want 0", rej_cnt - r0);
        end
        tests++;
        if (a !== exp_a) begin
            fails++;
            $display("FAIL dime_a_hold: got %0d want %0d", a, exp_a);
        end
    endtask

    task automatic test_bounce();
        int c0, r0, n;
        c0 = c_cnt;
        r0 = rej_cnt;
        coin_type = 2'd2;
        en = 1'b1;
        drive(1'b0, 2);
        for (int i = 0; i < 6; i++) drive(i % 2 == 0, 1);
        n = cyc + 1;
        drive(1'b1, 20);
        exp_a = 8'd25;
        drive(1'b0, 1);
        drive(1'b1, 1);
        drive(1'b0, D + 10);
        tests++;
        if (c_cnt - c0 !== 1) begin
            fails++;
            $display("FAIL bounce_c_count: got %0d want 1", c_cnt - c0);
        end
        tests++;
        if (rej_cnt - r0 !== 0) begin
            fails++;
            $display("FAIL bounce_reject: got %0d want 0", rej_cnt - r0);
        end
        tests++;
        if (strobe_edge !== n + 2 + D) begin
            fails++;
            $display("FAIL bounce_edge: got %0d want %0d", strobe_edge, n + 2 + D);
        end
        tests++;
        if (a !== exp_a) begin
            fails++;
            $display("FAIL bounce_a: got %0d want %0d", a, exp_a);
        end
    endtask

    task automatic test_refusals();
        int c0, r0;
        logic [1:0] tt [2] = '{2'd3, 2'd0};
        logic       ee [2] = '{1'b1, 1'b0};
        for (int k = 0; k < 2; k++) begin
            c0 = c_cnt;
            r0 = rej_cnt;
            coin_type = tt[k];
            en = ee[k];
            drive(1'b0, 2);
            drive(1'b1, 10);
            drive(1'b0, D + 6);
            tests++;
            if (rej_cnt - r0 !== 1) begin
                fails++;
                $display("FAIL refuse%0d_reject: got %0d want 1", k, rej_cnt - r0);
            end
            tests++;
            if (c_cnt - c0 !== 0) begin
                fails++;
                $display("FAIL refuse%0d_c: got %0d want 0", k, c_cnt - c0);
            end
            tests++;
            if (a !== exp_a) begin
                fails++;
                $display("FAIL refuse%0d_a: got %0d want %0d", k, a, exp_a);
            end
        end
        c0 = c_cnt;
        r0 = rej_cnt;
        coin_type = 2'd1;
        en = 1'b1;
        drive(1'b0, 2);
        drive(1'b1, 3);
        drive(1'b0, D + 6);
        tests++;
        if (c_cnt - c0 !== 0) begin
            fails++;
            $display("FAIL glitch_c: got %0d want 0", c_cnt - c0);
        end
        tests++;
        if (rej_cnt - r0 !== 0) begin
            fails++;
            $display("FAIL glitch_reject: got %0d want 0", rej_cnt - r0);
        end
    endtask

    task automatic test_min_width();
        int c0, r0, n;
        c0 = c_cnt;
        r0 = rej_cnt;
        coin_type = 2'd0;
        en = 1'b1;
        drive(1'b0, 2);
        drive(1'b1, D);
        drive(1'b0, D + 6);
        tests++;
        if ((c_cnt - c0) + (rej_cnt - r0) !== 0) begin
            fails++;
            $display("FAIL width_short: got %0d strobes want 0",
                     (c_cnt - c0) + (rej_cnt - r0));
        end
        c0 = c_cnt;
        n = cyc + 1;
        drive(1'b1, D + 1);
        exp_a = 8'd5;
        drive(1'b0, D + 6);
        tests++;
        if (c_cnt - c0 !== 1) begin
            fails++;
            $display("FAIL width_min_c: got %0d want 1", c_cnt - c0);
        end
        tests++;
        if (strobe_edge !== n + 2 + D) begin
            fails++;
            $display("FAIL width_min_edge: got %0d want %0d", strobe_edge, n + 2 + D);
        end
    endtask

    task automatic test_jam();
        int c0, n, m;
        c0 = c_cnt;
        jam_rise = -1;
        jam_fall = -1;
        coin_type = 2'd2;
        en = 1'b1;
        drive(1'b0, 2);
        n = cyc + 1;
        drive(1'b1, 30);
        exp_a = 8'd25;
        m = cyc + 1;
        drive(1'b0, D + 8);
        tests++;
        if (jam_rise !== n + 2 + D + JAM) begin
            fails++;
            $display("FAIL jam_rise: got %0d want %0d", jam_rise, n + 2 + D + JAM);
        end
        tests++;
        if (jam_fall !== m + 2 + D) begin
            fails++;
            $display("FAIL jam_fall: got %0d want %0d", jam_fall, m + 2 + D);
        end
        tests++;
        if (c_cnt - c0 !== 1) begin
            fails++;
            $display("FAIL jam_c_count: got %0d want 1", c_cnt - c0);
        end
    endtask

    task automatic test_reset_mid();
        int c0, n;
        coin_type = 2'd2;
        en = 1'b1;
        drive(1'b0, 2);
        drive(1'b1, 25);
        exp_a = 8'd25;
        tests++;
        if (jam !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_pre_jam: got %b want 1", jam);
        end
        tests++;
        if (a !== exp_a) begin
            fails++;
            $display("FAIL rstmid_pre_a: got %0d want %0d", a, exp_a);
        end
        rst = 1'b0;
        #2;
        exp_a = 8'd0;
        tests++;
        if (c !== 1'b0 || reject !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_strobes: got c=%b reject=%b want 0 0", c, reject);
        end
        tests++;
        if (jam !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_jam: got %b want 0", jam);
        end
        tests++;
        if (a !== exp_a) begin
            fails++;
            $display("FAIL rstmid_a: got %0d want 0", a);
        end
        tick();
        tick();
        c0 = c_cnt;
        rst = 1'b1;
        n = cyc + 1;
        drive(1'b1, 20);
        exp_a = 8'd25;
        drive(1'b0, D + 10);
        tests++;
        if (c_cnt - c0 !== 1) begin
            fails++;
            $display("FAIL rstmid_reeval: got %0d want 1", c_cnt - c0);
        end
        tests++;
        if (strobe_edge !== n + 2 + D) begin
            fails++;
            $display("FAIL rstmid_edge: got %0d want %0d", strobe_edge, n + 2 + D);
        end
        tests++;
        if (a !== exp_a) begin
            fails++;
            $display("FAIL rstmid_a_after: got %0d want %0d", a, exp_a);
        end
    endtask

    task automatic test_back_to_back();
        int c0, acc0, total;
        c0 = c_cnt;
        acc0 = acc;
        total = 0;
        en = 1'b1;
        for (int t = 0; t < 3; t++) begin
            coin_type = 2'(t);
            drive(1'b1, 10);
            drive(1'b0, 10);
            exp_a = value_of(2'(t));
            total += int'(exp_a);
            tests++;
            if (a !== exp_a) begin
                fails++;
                $display("FAIL b2b_a%0d: got %0d want %0d", t, a, exp_a);
            end
        end
        tests++;
        if (c_cnt - c0 !== 3) begin
            fails++;
            $display("FAIL b2b_tot_ld: got %0d want 3", c_cnt - c0);
        end
        tests++;
        if (acc - acc0 !== total) begin
            fails++;
            $display("FAIL b2b_total: got %0d want %0d", acc - acc0, total);
        end
    endtask

    task automatic test_random();
        int c0, r0, n, h, l;
        logic [1:0] t;
        logic e, ok, jam_exp;
        for (int k = 0; k < 12; k++) begin
            t = 2'($urandom_range(0, 3));
            e = 1'($urandom_range(0, 1));
            h = $urandom_range(D + 3, D + 15);
            l = $urandom_range(D + 3, D + 8);
            ok = e && (t != 2'd3);
            jam_exp = (h - D) >= JAM;
            c0 = c_cnt;
            r0 = rej_cnt;
            jam_rise = -1;
            coin_type = t;
            en = e;
            drive(1'b0, 2);
            n = cyc + 1;
            drive(1'b1, D + 3);
            en = ~e;
            drive(1'b1, h - (D + 3));
            drive(1'b0, l);
            if (ok) exp_a = value_of(t);
            tests++;
            if (c_cnt - c0 !== int'(ok)) begin
                fails++;
                $display("FAIL rnd%0d_c: got %0d want %0d", k, c_cnt - c0, ok);
            end
            tests++;
            if (rej_cnt - r0 !== int'(!ok)) begin
                fails++;
                $display("FAIL rnd%0d_reject: got %0d want %0d", k, rej_cnt - r0, !ok);
            end
            tests++;
            if (strobe_edge !== n + 2 + D) begin
                fails++;
                $display("FAIL rnd%0d_edge: got %0d want %0d", k, strobe_edge, n + 2 + D);
            end
            tests++;
            if (a !== exp_a) begin
                fails++;
                $display("FAIL rnd%0d_a: got %0d want %0d", k, a, exp_a);
            end
            tests++;
            if ((jam_rise != -1) !== jam_exp) begin
                fails++;
                $display("FAIL rnd%0d_jam: got %b want %b", k, jam_rise != -1, jam_exp);
            end
        end
    endtask

    task automatic test_debounce_one();
        int n, hits, edge_at;
        hits = 0;
        edge_at = -1;
        n = cyc + 1;
        for (int i = 0; i < 12; i++) begin
            sense1 = (i < 6);
            tick();
            if (c1 === 1'b1) begin
                hits++;
                edge_at = cyc;
            end
        end
        tests++;
        if (hits !== 1) begin
            fails++;
            $display("FAIL d1_count: got %0d want 1", hits);
        end
        tests++;
        if (edge_at !== n + 3) begin
            fails++;
            $display("FAIL d1_edge: got %0d want %0d", edge_at, n + 3);
        end
        tests++;
        if (a1 !== 8'd10) begin
            fails++;
            $display("FAIL d1_a: got %0d want 10", a1);
        end
    endtask

    initial begin
        test_reset();
        test_clean_dime();
        test_bounce();
        test_refusals();
        test_min_width();
        test_jam();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_debounce_one();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
